tag_release_queue: RTL
======================

// Module: tag_release_queue
// PURPOSE
//   Return side of the L1D tag freelist. Records every tag handed out by the freelist in allocation
//   order, marks tags done as completions arrive out of order, and hands them back to the freelist
//   strictly in allocation order. rel_vld_o/rel_tag_o drive the freelist enqueue port directly.
// PARAMETERS
//   ENTRY_COUNT      4                      number of tracked tags; equals the freelist depth; need not be a power of 2
//   TAG_WIDTH        $clog2(ENTRY_COUNT)    tag width (localparam)
//   CNT_WIDTH        $clog2(ENTRY_COUNT+1)  occupancy counter width (localparam)
// PORTS
//   clk          in   1          clock, rising edge
//   rst_n        in   1          asynchronous reset, active low
//   alloc_vld_i  in   1          tag alloc_tag_i was dequeued from the freelist this cycle
//   alloc_tag_i  in   TAG_WIDTH  allocated tag
//   alloc_rdy_o  out  1          queue not full; alloc accepted only when alloc_vld_i & alloc_rdy_o
//   cmpl_vld_i   in   1          transaction owning cmpl_tag_i has finished
//   cmpl_tag_i   in   TAG_WIDTH  completed tag, any order
//   rel_vld_o    out  1          head tag is done and is being returned this cycle; no back-pressure
//   rel_tag_o    out  TAG_WIDTH  tag returned to the freelist
//   cmpl_err_o   out  1          registered pulse: previous-cycle completion matched no pending entry
//   cnt_o        out  CNT_WIDTH  number of occupied entries
//   flush_i      in   1          drop all tracked tags; freelist re-initialises itself in the same cycle
// BEHAVIOUR
//   - Storage: ENTRY_COUNT slots {tag, vld, done}. head/tail pointers each carry a wrap flag.
//     empty = ptrs equal & flags equal; full = ptrs equal & flags differ.
//   - Pointer increment: slot ENTRY_COUNT-1 wraps to 0 and toggles the flag. Use plain +1 when
//     ENTRY_COUNT is a power of 2.
//   - Reset (async, rst_n=0): head=tail=0, both flags 0, all vld/done=0, cnt_o=0, cmpl_err_o=0.
//     Outputs while in reset: alloc_rdy_o=1, rel_vld_o=0.
//   - alloc_rdy_o = ~full. It is computed from registered state only and is independent of a same-cycle release.
//   - Alloc fire: slot[tail] <= {alloc_tag_i, vld=1, done=0}; tail advances at the next edge.
//   - Completion: cmpl_tag_i is compared against every slot with vld=1 & done=0, using pre-edge state.
//     On a match, that slot's done is set at the edge. A tag can sit in at most one live slot.
//     A completion with no match changes no state and sets cmpl_err_o=1 for exactly one cycle.
//   - Release (combinational from registered state):
//     rel_vld_o = ~empty & slot[head].done & ~flush_i;  rel_tag_o = slot[head].tag.
//     When rel_vld_o=1: slot[head].vld cleared and head advances at the edge.
//     At most one release per cycle.
//   - Latency: completion at edge N lets the tag release at the earliest in the cycle after edge N.
//     There is no same-cycle bypass from cmpl to rel.
//   - A done tag behind an undone head waits (in-order return). A run of done entries drains one per cycle.
//   - Simultaneous events in one cycle: alloc, cmpl and release all act independently.
//     - cnt_o next = cnt + alloc_fire - rel_vld_o.
//     - Alloc into full with release in the same cycle is NOT accepted.
//     - A completion for the tag being allocated in the same cycle does not match the new slot; it flags cmpl_err_o.
//   - Flush (priority over all else): at the edge, head=tail=0, flags=0, all vld/done=0, cnt_o=0,
//     cmpl_err_o=0. Alloc and cmpl in that cycle are dropped. rel_vld_o=0 during the flush cycle.
//   - Reset asserted mid-operation clears all state immediately. No partial release may be emitted
//     after rst_n falls.
//   - rel_tag_o is don't-care when rel_vld_o=0. It must not contain X after reset.
// TESTING
//   1 Reset then alloc tags 0,1,2,3 on consecutive cycles -> cnt_o=4, alloc_rdy_o=0, rel_vld_o=0.
//   2 From (1), cmpl 2, then 0, then 1 -> rel_vld_o with tag 0 one cycle after cmpl 0;
//     rel tags 1,2 on the next two cycles; tag 3 held.
//   3 Full queue + head done + alloc_vld_i in the same cycle -> release of the head tag,
//     alloc rejected, cnt_o drops by 1; alloc accepted on the next cycle.
//   4 ENTRY_COUNT=3: 10 alloc/cmpl/release rounds -> pointers wrap 2->0 with flag toggle,
//     release order equals alloc order, never full/empty mismatch against a reference model.
//   5 cmpl of an unallocated tag, and a repeated cmpl of a done tag -> cmpl_err_o=1 for one cycle each; no state change.
//   6 flush_i with 3 pending (1 done at head) -> rel_vld_o=0 that cycle, cnt_o=0 next cycle, alloc_rdy_o=1;
//     rst_n pulsed mid-drain -> outputs at reset values asynchronously.

Source files
------------

// File: rtl/tag_release_queue.sv
// In-order return queue for L1D tags: records allocations, marks out-of-order completions,
// and releases tags back to the freelist strictly in allocation order.
module tag_release_queue #(
  parameter  int ENTRY_COUNT = 4,
  localparam int TAG_WIDTH   = $clog2(ENTRY_COUNT),
  localparam int CNT_WIDTH   = $clog2(ENTRY_COUNT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc_vld_i,
  input  logic [TAG_WIDTH-1:0] alloc_tag_i,
  output logic                 alloc_rdy_o,
  input  logic                 cmpl_vld_i,
  input  logic [TAG_WIDTH-1:0] cmpl_tag_i,
  output logic                 rel_vld_o,
  output logic [TAG_WIDTH-1:0] rel_tag_o,
  output logic                 cmpl_err_o,
  output logic [CNT_WIDTH-1:0] cnt_o,
  input  logic                 flush_i
);

  logic [TAG_WIDTH-1:0]   tag_q [ENTRY_COUNT];
  logic [TAG_WIDTH-1:0]   tag_d [ENTRY_COUNT];
  logic [ENTRY_COUNT-1:0] vld_q, vld_d, done_q, done_d, match_s;
  logic [TAG_WIDTH:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [TAG_WIDTH-1:0]   head_idx_s, tail_idx_s;
  logic                   empty_s, full_s, alloc_fire_s;

  // Pointer MSB is the wrap flag; the index wraps at ENTRY_COUNT-1 even for non-power-of-2 depths.
  function automatic logic [TAG_WIDTH:0] ptr_inc(input logic [TAG_WIDTH:0] ptr);
    logic [TAG_WIDTH:0] nxt;
    if (ptr[TAG_WIDTH-1:0] == TAG_WIDTH'(ENTRY_COUNT - 1)) begin
      nxt = {~ptr[TAG_WIDTH], {TAG_WIDTH{1'b0}}};
    end else begin
      nxt = {ptr[TAG_WIDTH], ptr[TAG_WIDTH-1:0] + TAG_WIDTH'(1)};
    end
    return nxt;
  endfunction

  assign head_idx_s   = head_q[TAG_WIDTH-1:0];
  assign tail_idx_s   = tail_q[TAG_WIDTH-1:0];
  assign empty_s      = (head_q == tail_q);
  assign full_s       = (head_idx_s == tail_idx_s) && (head_q[TAG_WIDTH] != tail_q[TAG_WIDTH]);
  assign alloc_rdy_o  = ~full_s;
  assign alloc_fire_s = alloc_vld_i & ~full_s & ~flush_i;
  assign rel_vld_o    = ~empty_s & done_q[head_idx_s] & ~flush_i;
  assign rel_tag_o    = tag_q[head_idx_s];
  assign cmpl_err_o   = err_q;
  assign cnt_o        = cnt_q;

  // Completion lookup against live, not-yet-done slots using pre-edge state only.
  always_comb begin
    match_s = '0;
    for (int i = 0; i < ENTRY_COUNT; i++) begin
      if (cmpl_vld_i && vld_q[i] && !done_q[i] && (tag_q[i] == cmpl_tag_i)) begin
        match_s[i] = 1'b1;
      end else begin
        match_s[i] = 1'b0;
      end
    end
  end

  // Next-state: flush wins; otherwise alloc, completion and release act on distinct slots.
  always_comb begin
    tag_d  = tag_q;
    vld_d  = vld_q;
    done_d = done_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    err_d  = 1'b0;
    if (flush_i) begin
      vld_d  = '0;
      done_d = '0;
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
      err_d  = 1'b0;
    end else begin
      done_d = done_q | match_s;
      err_d  = cmpl_vld_i & ~(|match_s);
      if (alloc_fire_s) begin
        tag_d[tail_idx_s]  = alloc_tag_i;
        vld_d[tail_idx_s]  = 1'b1;
        done_d[tail_idx_s] = 1'b0;
        tail_d             = ptr_inc(tail_q);
      end else begin
        tail_d = tail_q;
      end
      if (rel_vld_o) begin
        vld_d[head_idx_s]  = 1'b0;
        done_d[head_idx_s] = 1'b0;
        head_d             = ptr_inc(head_q);
      end else begin
        head_d = head_q;
      end
      cnt_d = cnt_q + CNT_WIDTH'(alloc_fire_s) - CNT_WIDTH'(rel_vld_o);
    end
  end

  // State registers; tags are reset too so rel_tag_o never carries X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRY_COUNT; i++) begin
        tag_q[i] <= '0;
      end
      vld_q  <= '0;
      done_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRY_COUNT; i++) begin
        tag_q[i] <= tag_d[i];
      end
      vld_q  <= vld_d;
      done_q <= done_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

endmodule
